// File: rtl/rr3_pkg.sv
// Shared encodings for the three-way round-robin arbiter.
// Latency: none (types, constants and pure helper functions).
// Backpressure: not applicable.
package rr3_pkg;

    // Arbiter FSM states; GNT_x encodings are requester index + 1.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2,
        ST_GNT_C = 2'd3
    } state_t;

    // Requester indices, also the bit positions in request/grant vectors.
    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;

    // Access time in cycles loaded at reset.
    localparam int ACC_DEFAULT_C = 4;

    function automatic state_t idx_to_state(input logic [1:0] idx);
        case (idx)
            IDX_A:   return ST_GNT_A;
            IDX_B:   return ST_GNT_B;
            default: return ST_GNT_C;
        endcase
    endfunction

    function automatic logic [2:0] idx_to_gnt(input logic [1:0] idx);
        case (idx)
            IDX_A:   return 3'b001;
            IDX_B:   return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Only meaningful for GNT_x states; IDLE maps to IDX_A and callers ignore it.
    function automatic logic [1:0] state_to_idx(input state_t s);
        case (s)
            ST_GNT_B: return IDX_B;
            ST_GNT_C: return IDX_C;
            default:  return IDX_A;
        endcase
    endfunction

endpackage

// File: rtl/rr3_next_owner.sv
// Rotated-priority picker: first requester after last_owner (A->B->C->A), last_owner itself last.
// Latency: purely combinational.
// Backpressure: none; o_vld low when no request is present.
module rr3_next_owner
    import rr3_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_last_owner,
    output logic [1:0] o_next_owner,
    output logic       o_vld
);

    logic [1:0] w_order [3];

    // Build the search order for this last_owner, then take the first requester in it.
    always_comb begin
        w_order[0] = IDX_A;
        w_order[1] = IDX_B;
        w_order[2] = IDX_C;
        case (i_last_owner)
            IDX_A: begin
                w_order[0] = IDX_B;
                w_order[1] = IDX_C;
                w_order[2] = IDX_A;
            end
            IDX_B: begin
                w_order[0] = IDX_C;
                w_order[1] = IDX_A;
                w_order[2] = IDX_B;
            end
            default: ;
        endcase

        o_vld        = 1'b0;
        o_next_owner = IDX_A;
        // Scan lowest priority first so the highest-priority requester overwrites.
        for (int i = 2; i >= 0; i--) begin
            if (i_req[w_order[i]]) begin
                o_vld        = 1'b1;
                o_next_owner = w_order[i];
            end
        end
    end

endmodule

// File: rtl/rr3_arbiter.sv
// Three-way round-robin arbiter with programmable access time under contention.
// Latency: grant registered, 1 cycle from request in IDLE; no bubble between owners.
// Backpressure: contended grants are revoked after acc_active cycles with a one-cycle timeout pulse.
module rr3_arbiter
    import rr3_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int ACC_DEFAULT = ACC_DEFAULT_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             req_c,
    input  logic             acc_set,
    input  logic [CNT_W-1:0] acc_time,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             gnt_c,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] ACC_RST = CNT_W'(ACC_DEFAULT);

    state_t           r_state;
    logic [2:0]       r_gnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_acc_active;
    logic [1:0]       r_last_owner;

    logic [2:0]       w_req;
    logic [1:0]       w_own;
    logic             w_own_req;
    logic [1:0]       w_search_from;
    logic [1:0]       w_pick;
    logic             w_pick_vld;
    logic [CNT_W-1:0] w_acc_set_val;
    logic [CNT_W-1:0] w_acc_nxt;

    assign w_req         = {req_c, req_b, req_a};
    assign w_own         = state_to_idx(r_state);
    assign w_own_req     = w_req[w_own];
    // While granted, search starts after the current owner so it is considered last.
    assign w_search_from = (r_state == ST_IDLE) ? r_last_owner : w_own;
    // Zero would mean an unbounded grant; clamp to one cycle.
    assign w_acc_set_val = (acc_time == '0) ? ONE : acc_time;
    // A grant starting this edge sees an acc_set arriving at the same edge.
    assign w_acc_nxt     = acc_set ? w_acc_set_val : r_acc;

    rr3_next_owner u_next_owner (
        .i_req        (w_req),
        .i_last_owner (w_search_from),
        .o_next_owner (w_pick),
        .o_vld        (w_pick_vld)
    );

    // Arbiter FSM with registered grants, timeout pulse, hold counter and access-time register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 3'b000;
            r_timeout    <= 1'b0;
            r_cnt        <= '0;
            r_acc        <= ACC_RST;
            r_acc_active <= ACC_RST;
            r_last_owner <= IDX_C;
        end else begin
            r_timeout <= 1'b0;
            if (acc_set) begin
                r_acc <= w_acc_set_val;
            end

            if (r_state == ST_IDLE) begin
                if (w_pick_vld) begin
                    r_state      <= idx_to_state(w_pick);
                    r_gnt        <= idx_to_gnt(w_pick);
                    r_cnt        <= '0;
                    r_acc_active <= w_acc_nxt;
                end
            end else if (!w_own_req) begin
                // Release wins over a coincident expiry, so no timeout here.
                r_last_owner <= w_own;
                r_cnt        <= '0;
                if (w_pick_vld) begin
                    r_state      <= idx_to_state(w_pick);
                    r_gnt        <= idx_to_gnt(w_pick);
                    r_acc_active <= w_acc_nxt;
                end else begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 3'b000;
                end
            end else if (r_cnt == r_acc_active - ONE) begin
                // Access time used up: preempt if someone else waits, else hold saturated.
                if (w_pick_vld && (w_pick != w_own)) begin
                    r_state      <= idx_to_state(w_pick);
                    r_gnt        <= idx_to_gnt(w_pick);
                    r_cnt        <= '0;
                    r_acc_active <= w_acc_nxt;
                    r_timeout    <= 1'b1;
                    r_last_owner <= w_own;
                end
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

    assign gnt_a   = r_gnt[IDX_A];
    assign gnt_b   = r_gnt[IDX_B];
    assign gnt_c   = r_gnt[IDX_C];
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr3_arbiter.sv
module tb_rr3_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, req_c;
    logic       acc_set;
    logic [3:0] acc_time;
    logic       gnt_a, gnt_b, gnt_c, timeout;

    int n_chk  = 0;
    int n_pass = 0;

    rr3_arbiter #(.CNT_W(4), .ACC_DEFAULT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_c    (req_c),
        .acc_set  (acc_set),
        .acc_time (acc_time),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .gnt_c    (gnt_c),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Advance one cycle and compare {gnt_a,gnt_b,gnt_c,timeout} at the falling edge.
    task automatic cyc(input logic [3:0] exp, input string tag);
        logic [3:0] obs;
        @(negedge clk);
        obs = {gnt_a, gnt_b, gnt_c, timeout};
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got abc_to=%b expected %b at %0t", tag, obs, exp, $time);
    endtask

    // One grant of n cycles to the one-hot owner g (bits a,b,c); first cycle carries timeout=to.
    task automatic run(input logic [2:0] g, input logic to, input int n, input string tag);
        cyc({g, to}, tag);
        for (int i = 1; i < n; i++) cyc({g, 1'b0}, tag);
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        acc_set = 1'b0; acc_time = 4'd0;

        // Reset with no requests, then idle after release
        for (int i = 0; i < 5; i++) cyc(4'b0000, "NOREQ");
        rst_n = 1'b1;
        cyc(4'b0000, "NOREQ_IDLE");

        // Single requesters: grant after one cycle, held indefinitely, IDLE on drop
        req_a = 1'b1;
        run(3'b100, 1'b0, 11, "REQFA");
        req_a = 1'b0;
        cyc(4'b0000, "REQFA_DROP");
        req_b = 1'b1;
        run(3'b010, 1'b0, 6, "REQFB");
        req_b = 1'b0;
        cyc(4'b0000, "REQFB_DROP");
        req_c = 1'b1;
        run(3'b001, 1'b0, 6, "REQFC");
        req_c = 1'b0;
        cyc(4'b0000, "REQFC_DROP");

        // Access time 2, A and B contend (last owner C, so A first)
        acc_set = 1'b1; acc_time = 4'd2;
        cyc(4'b0000, "ATCAB_SET");
        acc_set = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        run(3'b100, 1'b0, 2, "ATCAB_A1");
        run(3'b010, 1'b1, 2, "ATCAB_B1");
        run(3'b100, 1'b1, 2, "ATCAB_A2");
        run(3'b010, 1'b1, 2, "ATCAB_B2");

        // Release B with an acc_set of 4 in the same cycle; last owner becomes B
        req_a = 1'b0; req_b = 1'b0; acc_set = 1'b1; acc_time = 4'd4;
        cyc(4'b0000, "ATCBC_SET");
        acc_set = 1'b0;
        req_b = 1'b1; req_c = 1'b1;
        run(3'b001, 1'b0, 4, "ATCBC_C1");
        run(3'b010, 1'b1, 4, "ATCBC_B1");
        run(3'b001, 1'b1, 4, "ATCBC_C2");
        req_b = 1'b0; req_c = 1'b0;
        cyc(4'b0000, "ATCBC_DROP");

        // C and A contend; last owner C so A first; then B joins for full rotation
        req_c = 1'b1; req_a = 1'b1;
        run(3'b100, 1'b0, 4, "ATCCA_A1");
        run(3'b001, 1'b1, 4, "ATCCA_C1");
        run(3'b100, 1'b1, 1, "ATCCA_A2");
        req_b = 1'b1;
        run(3'b100, 1'b0, 3, "ATC3_A");
        run(3'b010, 1'b1, 4, "ATC3_B");
        run(3'b001, 1'b1, 4, "ATC3_C");
        run(3'b100, 1'b1, 1, "ATC3_A2");
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        cyc(4'b0000, "ATC3_DROP");

        // acc_time=0 set at grant start acts as 1: pure rotation (last owner A, so B first)
        acc_set = 1'b1; acc_time = 4'd0; req_a = 1'b1; req_b = 1'b1;
        cyc(4'b0100, "SACC0_B");
        acc_set = 1'b0;
        cyc(4'b1001, "SACC0_A");
        cyc(4'b0101, "SACC0_B2");
        cyc(4'b1001, "SACC0_A2");

        // Change limit to 7 mid-grant: current grant keeps limit 2, next grant uses 7
        req_a = 1'b0; req_b = 1'b0; acc_set = 1'b1; acc_time = 4'd2;
        cyc(4'b0000, "SACC_IDLE");
        acc_set = 1'b0; req_a = 1'b1;
        run(3'b100, 1'b0, 3, "SACC_A");
        acc_set = 1'b1; acc_time = 4'd7;
        cyc(4'b1000, "SACC_SET7");
        acc_set = 1'b0; req_b = 1'b1;
        run(3'b010, 1'b1, 7, "SACC_B7");
        run(3'b100, 1'b1, 1, "SACC_A7");

        // A releases, B takes over; reset mid-grant drops it
        req_a = 1'b0;
        cyc(4'b0100, "RST_BGNT");
        rst_n = 1'b0; req_b = 1'b0;
        cyc(4'b0000, "RST_DROP");
        // After reset last owner is C and access time is back to 4
        rst_n = 1'b1; req_a = 1'b1; req_c = 1'b1;
        run(3'b100, 1'b0, 4, "RST_A_FIRST");
        run(3'b001, 1'b1, 1, "RST_C_NEXT");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
